// File: rtl/stream_config_pkg.sv
`default_nettype none
// ============================================================================
// Module : stream_config (package)
// Brief  : Shared byte-stream framing constants, state encoding and helpers
// Rev    : 1.0 - initial release
// ============================================================================
package stream_config;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } stream_state_e;

  // Number of whole bytes needed to carry a word of the given width.
  function automatic int num_bytes(input int width, input int byte_width);
    return (width + byte_width - 1) / byte_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_sink_serializer.sv
`default_nettype none
// ============================================================================
// Module : stream_sink_serializer
// Brief  : Splits each sink packet into MSB-first bytes on a valid/ready stream
// Rev    : 1.0 - initial release
// ============================================================================
module stream_sink_serializer #(
  parameter int PKT_WIDTH  = 16,
  parameter int BYTE_WIDTH = stream_config::BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  snk_valid,
  output logic                  snk_ready,
  input  logic [PKT_WIDTH-1:0]  snk,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [BYTE_WIDTH-1:0] tx_data,
  output logic                  busy
);
  import stream_config::*;

  localparam int NUM_BYTES = num_bytes(PKT_WIDTH, BYTE_WIDTH);
  localparam int SR_W      = NUM_BYTES * BYTE_WIDTH;
  localparam int PAD       = SR_W - PKT_WIDTH;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  stream_state_e    state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            w_last;
  logic            w_tx_fire;
  logic            w_accept;
  logic [SR_W-1:0] w_load;
  logic [SR_W-1:0] w_shift;

  // Left-align the packet so any padding lands in the last byte's LSBs.
  assign w_load    = SR_W'(snk) << PAD;
  assign w_shift   = sr_q << BYTE_WIDTH;
  assign w_last    = (cnt_q == '0);
  assign w_tx_fire = (state_q == SEND) && tx_ready;

  // Combinational path from tx_ready lets the next packet load on the last byte.
  assign snk_ready = (state_q == IDLE) || ((state_q == SEND) && w_last && tx_ready);
  assign w_accept  = snk_valid && snk_ready;

  assign tx_valid = (state_q == SEND);
  assign busy     = (state_q == SEND);
  assign tx_data  = sr_q[SR_W-1 -: BYTE_WIDTH];

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          sr_d    = w_load;
          cnt_d   = LAST_CNT;
          state_d = SEND;
        end
      end
      SEND: begin
        if (w_tx_fire) begin
          if (!w_last) begin
            sr_d  = w_shift;
            cnt_d = cnt_q - 1'b1;
          end else if (snk_valid) begin
            sr_d  = w_load;
            cnt_d = LAST_CNT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_sink_serializer.sv
`default_nettype none
// ============================================================================
// Module : tb_stream_sink_serializer
// Brief  : Scoreboard bench for three serializer widths (12, 16 and 3 bits)
// Rev    : 1.0 - initial release
// ============================================================================
module tb_stream_sink_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        snk_valid [3];
  logic [23:0] snk_v     [3];
  logic        tx_ready  [3];
  logic        snk_ready [3];
  logic        tx_valid  [3];
  logic        busy      [3];
  logic [7:0]  txd       [3];

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  always #5 clk = ~clk;

  stream_sink_serializer #(.PKT_WIDTH(12), .BYTE_WIDTH(8)) dut0 (
    .clk(clk), .rst(rst), .snk_valid(snk_valid[0]), .snk_ready(snk_ready[0]),
    .snk(snk_v[0][11:0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .tx_data(txd[0]), .busy(busy[0]));

  stream_sink_serializer #(.PKT_WIDTH(16), .BYTE_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .snk_valid(snk_valid[1]), .snk_ready(snk_ready[1]),
    .snk(snk_v[1][15:0]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .tx_data(txd[1]), .busy(busy[1]));

  stream_sink_serializer #(.PKT_WIDTH(3), .BYTE_WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .snk_valid(snk_valid[2]), .snk_ready(snk_ready[2]),
    .snk(snk_v[2][2:0]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .tx_data(txd[2]), .busy(busy[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [7:0] b);
    case (d)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic check_pop(input int d, input logic [7:0] act);
    logic [7:0] exp;
    int         sz;
    sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    n_checks++;
    if (sz == 0) begin
      n_err++;
      $display("FAIL dut%0d unexpected byte: got %0h expected none", d, act);
    end else begin
      case (d)
        0: exp = q0.pop_front();
        1: exp = q1.pop_front();
        default: exp = q2.pop_front();
      endcase
      if (act !== exp) begin
        n_err++;
        $display("FAIL dut%0d byte: got %0h expected %0h", d, act, exp);
      end
    end
  endtask

  // Monitor: a byte is transferred on the next rising edge when valid and ready meet.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (tx_valid[d] === 1'b1 && tx_ready[d] === 1'b1) check_pop(d, txd[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [23:0] p);
    logic ok;
    int   n;
    snk_v[d]     = p;
    snk_valid[d] = 1'b1;
    n = 0;
    do begin
      #1;
      ok = snk_ready[d];
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    snk_valid[d] = 1'b0;
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL dut%0d accept timeout: got no snk_ready expected accept", d);
    end
  endtask

  initial begin
    logic [11:0] pkt;
    logic        acc;
    int          sent;
    int          cyc;

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      snk_valid[d] = 1'b0;
      snk_v[d]     = '0;
      tx_ready[d]  = 1'b0;
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      check("reset tx_valid", 32'(tx_valid[d]), 32'd0);
      check("reset busy", 32'(busy[d]), 32'd0);
      check("reset tx_data", 32'(txd[d]), 32'd0);
      check("reset snk_ready", 32'(snk_ready[d]), 32'd1);
    end
    rst = 1'b0;
    tick();

    // 12-bit packet: padding in the last byte, busy for exactly two cycles.
    tx_ready[0] = 1'b1;
    push(0, 8'hAB);
    push(0, 8'hC0);
    send(0, 24'h000ABC);
    check("t1 first byte latency", {23'd0, tx_valid[0], txd[0]}, {23'd0, 1'b1, 8'hAB});
    check("t1 busy c1", 32'(busy[0]), 32'd1);
    tick();
    check("t1 second byte", 32'(txd[0]), 32'hC0);
    check("t1 busy c2", 32'(busy[0]), 32'd1);
    tick();
    check("t1 idle tx_valid", 32'(tx_valid[0]), 32'd0);
    check("t1 idle busy", 32'(busy[0]), 32'd0);

    // Back-to-back 16-bit packets with no gap.
    tx_ready[1] = 1'b1;
    push(1, 8'h12); push(1, 8'h34); push(1, 8'h56); push(1, 8'h78);
    send(1, 24'h001234);
    check("t2 first byte", 32'(txd[1]), 32'h12);
    #1;
    check("t2 snk_ready mid packet", 32'(snk_ready[1]), 32'd0);
    send(1, 24'h005678);
    check("t2 gapless next packet", {23'd0, tx_valid[1], txd[1]}, {23'd0, 1'b1, 8'h56});
    tick();
    check("t2 last byte", 32'(txd[1]), 32'h78);
    check("t2 snk_ready on last byte", 32'(snk_ready[1]), 32'd1);
    tick();
    check("t2 idle", 32'(busy[1]), 32'd0);

    // Backpressure holds the first byte stable.
    tx_ready[1] = 1'b0;
    push(1, 8'hBE); push(1, 8'hEF);
    send(1, 24'h00BEEF);
    snk_v[1] = 24'h00FFFF;
    for (int i = 0; i < 3; i++) begin
      check("t3 hold data", {23'd0, tx_valid[1], txd[1]}, {23'd0, 1'b1, 8'hBE});
      tick();
    end
    tx_ready[1] = 1'b1;
    tick();
    check("t3 second byte after release", 32'(txd[1]), 32'hEF);
    tick();
    check("t3 idle", 32'(tx_valid[1]), 32'd0);

    // Reset mid-packet; a simultaneous snk_valid elsewhere must be ignored.
    push(1, 8'hC0); push(1, 8'hFE);
    send(1, 24'h00C0FE);
    tick();
    tx_ready[1]  = 1'b0;
    rst          = 1'b1;
    snk_v[0]     = 24'h000123;
    snk_valid[0] = 1'b1;
    q1.delete();
    tick();
    rst          = 1'b0;
    snk_valid[0] = 1'b0;
    check("t4 reset tx_valid", 32'(tx_valid[1]), 32'd0);
    check("t4 reset busy", 32'(busy[1]), 32'd0);
    check("t4 reset beats snk_valid", 32'(tx_valid[0]), 32'd0);
    tx_ready[1] = 1'b1;
    push(1, 8'h01); push(1, 8'h02);
    send(1, 24'h000102);
    check("t4 restart first byte", 32'(txd[1]), 32'h01);
    repeat (2) tick();

    // Single-byte packets: every handshake is a last-byte handshake.
    tx_ready[2] = 1'b1;
    push(2, 8'hA0); push(2, 8'h60);
    send(2, 24'h000005);
    check("t5 single byte", 32'(txd[2]), 32'hA0);
    #1;
    check("t5 snk_ready with tx handshake", 32'(snk_ready[2]), 32'd1);
    send(2, 24'h000003);
    check("t5 next single byte", 32'(txd[2]), 32'h60);
    tick();
    check("t5 idle", 32'(busy[2]), 32'd0);

    // Random valid/ready traffic on the 12-bit instance.
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      tx_ready[0] = ($urandom_range(0, 3) != 0);
      if (!snk_valid[0] && $urandom_range(0, 1) == 1) begin
        pkt          = 12'($urandom);
        snk_v[0]     = {12'd0, pkt};
        snk_valid[0] = 1'b1;
        push(0, pkt[11:4]);
        push(0, {pkt[3:0], 4'h0});
      end
      #1;
      acc = snk_valid[0] && snk_ready[0];
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        snk_valid[0] = 1'b0;
        sent++;
      end
    end
    check("t6 packets accepted", 32'(sent), 32'd1000);
    tx_ready[0] = 1'b1;
    cyc = 0;
    while (q0.size() != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    repeat (2) tick();
    check("drain q0 empty", 32'(q0.size()), 32'd0);
    check("drain q1 empty", 32'(q1.size()), 32'd0);
    check("drain q2 empty", 32'(q2.size()), 32'd0);
    check("final idle", 32'(busy[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
